// File: rtl/matrix_pixel_streamer.sv
// Streams a snapshot of the 16x16 occupancy matrix as 256 serpentine-ordered GRB pixel words.
// A frame is started by the refresh timer or by force_frame. After the last pixel, a latch gap
// is held before frame_done pulses.
//
// Ports:
//   clk, reset   - system clock; asynchronous active-high reset
//   matrix       - cell occupancy, matrix[row][col]; sampled only while a frame is latched
//   force_frame  - single-cycle request to start a frame now
//   pix_data     - GRB pixel word (registered)
//   pix_valid    - pix_data holds a pixel (registered)
//   pix_ready    - the serializer accepts the pixel when pix_valid is high
//   pix_last     - high together with pixel 255 (registered)
//   frame_busy   - a frame is being latched, streamed or followed by its gap
//   frame_done   - one-cycle pulse on the last gap cycle
module matrix_pixel_streamer #(
  parameter int unsigned REFRESH_CYCLES = 416667,
  parameter int unsigned GAP_CYCLES     = 2000,
  parameter logic [23:0] ON_COLOR       = 24'h101010,
  parameter logic [23:0] OFF_COLOR      = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        matrix [16][16],
  input  logic        force_frame,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_busy,
  output logic        frame_done
);

  localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLatch, StStream, StGap} state_e;

  state_e            state_q, state_d;
  logic [RefW-1:0]   refresh_q, refresh_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [7:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [15:0][15:0] snap_q, snap_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              pix_last_q, pix_last_d;

  logic              refresh_tick;
  logic              start_req;
  logic [3:0]        pix_row, pix_col;

  always_comb begin
    refresh_tick = (refresh_q == RefLast);
    refresh_d    = refresh_tick ? '0 : refresh_q + 1'b1;
    start_req    = refresh_tick | force_frame;

    state_d    = state_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    snap_d     = snap_q;
    frame_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_req || pending_q) begin
          state_d   = StLatch;
          pending_d = 1'b0;
        end
      end
      StLatch: begin
        for (int r = 0; r < 16; r++) begin
          for (int c = 0; c < 16; c++) begin
            snap_d[r][c] = matrix[r][c];
          end
        end
        idx_d   = 8'd0;
        state_d = StStream;
      end
      StStream: begin
        // pix_valid is always high in this state, so ready alone marks an accept.
        if (pix_ready) begin
          if (idx_q == 8'hff) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request that cannot be served now is remembered once; further ones are dropped.
    if (start_req && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    // Output registers are loaded from next-state values so pixel 0 appears the cycle after
    // LATCH, straight from the snapshot being captured.
    pix_row     = idx_d[7:4];
    pix_col     = idx_d[4] ? ~idx_d[3:0] : idx_d[3:0];  // odd rows run right-to-left
    pix_valid_d = (state_d == StStream);
    pix_last_d  = pix_valid_d && (idx_d == 8'hff);
    pix_data_d  = '0;
    if (pix_valid_d) begin
      pix_data_d = snap_d[pix_row][pix_col] ? ON_COLOR : OFF_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      refresh_q   <= '0;
      gap_q       <= '0;
      idx_q       <= 8'd0;
      pending_q   <= 1'b0;
      snap_q      <= '0;
      pix_data_q  <= 24'd0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      refresh_q   <= refresh_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      snap_q      <= snap_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_last   = pix_last_q;
  assign frame_busy = (state_q != StIdle);

endmodule

// File: tb/tb_matrix_pixel_streamer.sv
// Bench for matrix_pixel_streamer: a frame-level model (queue of expected pixels built in
// serpentine order at latch time) is compared against the DUT every cycle, and directed
// scenarios pin timing and content with literal expectations.
module tb_matrix_pixel_streamer;

  localparam int unsigned R   = 300;
  localparam int unsigned G   = 10;
  localparam logic [23:0] ON  = 24'h101010;
  localparam logic [23:0] OFF = 24'h000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        matrix [16][16];
  logic        force_frame;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        frame_busy;
  logic        frame_done;

  matrix_pixel_streamer #(
    .REFRESH_CYCLES(R),
    .GAP_CYCLES    (G),
    .ON_COLOR      (ON),
    .OFF_COLOR     (OFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .matrix     (matrix),
    .force_frame(force_frame),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .frame_busy (frame_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail_print = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      if (n_fail_print < 40) begin
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
      n_fail_print++;
    end
  endtask

  // ---------------- frame-level model ----------------
  int unsigned m_ref = 0;
  bit          m_latch = 1'b0;
  bit          m_stream = 1'b0;
  bit          m_pending = 1'b0;
  int          m_gap_left = 0;
  logic [23:0] m_q[$];
  bit          m_req;
  bit          m_busy_before;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_ref = 0; m_latch = 0; m_stream = 0; m_pending = 0; m_gap_left = 0;
      m_q.delete();
    end else begin
      m_req = (m_ref == R - 1) || force_frame;
      m_ref = (m_ref + 1) % R;
      m_busy_before = m_latch || m_stream || (m_gap_left > 0);
      if (m_latch) begin
        m_q.delete();
        for (int r = 0; r < 16; r++) begin
          for (int k = 0; k < 16; k++) begin
            m_q.push_back(matrix[r][(r % 2 == 0) ? k : 15 - k] ? ON : OFF);
          end
        end
        m_latch = 0;
        m_stream = 1;
      end else if (m_stream) begin
        if (pix_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_stream = 0;
            m_gap_left = G;
          end
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (m_req || m_pending) begin
        m_latch = 1;
        m_pending = 0;
      end
      if (m_req && m_busy_before) m_pending = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("pix_valid", pix_valid, m_stream);
    check("frame_busy", frame_busy, m_latch || m_stream || (m_gap_left > 0));
    check("frame_done", frame_done, m_gap_left == 1);
    if (m_stream && m_q.size() > 0) begin
      check("pix_data", pix_data, m_q[0]);
      check("pix_last", pix_last, m_q.size() == 1);
    end else if (reset) begin
      check("pix_data_rst", pix_data, 0);
      check("pix_last_rst", pix_last, 0);
    end
  end

  // ---------------- frame event monitor ----------------
  bit          prev_busy = 0;
  int          n_latch = 0, n_done = 0;
  int          latch_cyc = 0, done_cyc = 0, first_valid_cyc = -1, last_acc_cyc = 0;
  int          fr_acc = 0, fr_on = 0, fr_on_idx = -1, last_idx_at_last = -1;
  int          last_fr_acc = 0, last_fr_on = 0, last_fr_on_idx = -1;
  logic [23:0] first_pix = 24'd0;
  int          latch_hist[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_busy = 0;
      fr_acc = 0;
    end else begin
      if (frame_busy && !prev_busy) begin
        latch_cyc = cyc; n_latch++; latch_hist.push_back(cyc);
        fr_acc = 0; fr_on = 0; fr_on_idx = -1; first_valid_cyc = -1;
      end
      if (pix_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_pix = pix_data;
      end
      if (pix_valid && pix_ready) begin
        if (pix_data == ON) begin
          fr_on++;
          fr_on_idx = fr_acc;
        end
        if (pix_last) begin
          last_acc_cyc = cyc;
          last_idx_at_last = fr_acc;
        end
        fr_acc++;
      end
      if (frame_done) begin
        done_cyc = cyc; n_done++;
        last_fr_acc = fr_acc; last_fr_on = fr_on; last_fr_on_idx = fr_on_idx;
      end
      prev_busy = frame_busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  int rc = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic v);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) matrix[r][c] = v;
  endtask

  task automatic set_diag();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) matrix[r][c] = (r == c);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    rc = cyc;
    latch_hist.delete();
    fr_acc = 0;
  endtask

  task automatic pulse_force(output int p);
    force_frame = 1'b1;
    p = cyc;
    @(posedge clk);
    #1;
    force_frame = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int base = n_done;
    int k = 0;
    while (n_done == base && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(nm, n_done != base, 1);
  endtask

  task automatic wait_acc(input string nm, input int n, input int budget);
    int k = 0;
    while (fr_acc < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(nm, fr_acc >= n, 1);
  endtask

  task automatic wait_latch(input string nm, input int budget);
    int base = n_latch;
    int k = 0;
    while (n_latch == base && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(nm, n_latch != base, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int p, q, d, base, k;
    pix_ready = 1'b1;
    force_frame = 1'b0;
    set_all(1'b0);
    do_reset();

    // Single set cell at row 1, col 0: serpentine places it at index 31.
    set_all(1'b0);
    matrix[1][0] = 1'b1;
    step(2);
    pulse_force(p);
    wait_done("a_done", 400);
    check("a_latch_cyc", latch_cyc, p + 1);
    check("a_first_valid", first_valid_cyc, p + 2);
    check("a_accepts", last_fr_acc, 256);
    check("a_on_count", last_fr_on, 1);
    check("a_on_index", last_fr_on_idx, 31);
    check("a_last_index", last_idx_at_last, 255);
    check("a_done_gap", done_cyc - last_acc_cyc, G);

    // Reset in the middle of a frame, then a clean frame of the diagonal.
    do_reset();
    set_diag();
    step(1);
    pulse_force(p);
    wait_acc("b_reach40", 40, 200);
    base = n_done;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("b_rst_valid", pix_valid, 0);
    check("b_rst_busy", frame_busy, 0);
    check("b_rst_data", pix_data, 0);
    step(2);
    reset = 1'b0;
    rc = cyc;
    step(30);
    check("b_no_done", n_done, base);
    pulse_force(p);
    wait_done("b_done2", 400);
    check("b_first_valid", first_valid_cyc, p + 2);
    check("b_first_pix", first_pix, ON);
    check("b_accepts", last_fr_acc, 256);
    check("b_on_count", last_fr_on, 16);
    check("b_last_on_idx", last_fr_on_idx, 240);

    // Ready alternating, low on the first STREAM cycle.
    do_reset();
    set_diag();
    step(1);
    pulse_force(p);
    base = n_done;
    k = 0;
    while (n_done == base && k < 800) begin
      pix_ready = ((cyc - p) % 2 == 1);
      @(posedge clk);
      #1;
      k++;
    end
    check("c_done", n_done != base, 1);
    pix_ready = 1'b1;
    check("c_accepts", last_fr_acc, 256);
    check("c_on_count", last_fr_on, 16);
    check("c_last_on_idx", last_fr_on_idx, 240);
    check("c_stream_cycles", last_acc_cyc - first_valid_cyc + 1, 512);

    // Matrix flips to all-ones right after LATCH: this frame stays dark, the next is lit.
    do_reset();
    set_all(1'b0);
    step(1);
    pulse_force(p);
    step(1);
    set_all(1'b1);
    wait_done("d_done1", 400);
    check("d_on_count1", last_fr_on, 0);
    check("d_accepts1", last_fr_acc, 256);
    step(2);
    pulse_force(p);
    wait_done("d_done2", 400);
    check("d_on_count2", last_fr_on, 256);

    // Two force pulses mid-stream: one extra frame, LATCH two cycles after frame_done.
    do_reset();
    set_diag();
    step(1);
    pulse_force(p);
    wait_acc("e_reach50", 50, 200);
    pulse_force(q);
    step(10);
    pulse_force(q);
    wait_done("e_done", 400);
    d = done_cyc;
    wait_latch("e_relatch_seen", 20);
    check("e_relatch_cyc", latch_cyc, d + 2);

    // Free-running refresh: frames every R cycles.
    do_reset();
    step(950);
    check("f1_count", latch_hist.size(), 3);
    if (latch_hist.size() >= 3) begin
      check("f1_latch0", latch_hist[0], rc + 300);
      check("f1_latch1", latch_hist[1], rc + 600);
      check("f1_latch2", latch_hist[2], rc + 900);
    end

    // Ticks landing inside frames are deferred, not lost.
    do_reset();
    step(100);
    pulse_force(p);
    step(598);
    check("f2_count", latch_hist.size(), 3);
    if (latch_hist.size() >= 3) begin
      check("f2_latch0", latch_hist[0], rc + 101);
      check("f2_latch1", latch_hist[1], rc + 369);
      check("f2_latch2", latch_hist[2], rc + 637);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
